bcd_countdown: RTL and testbench

- Countdown counterpart to the stopwatch's up-counting path. Sits between the synch_edge_det button pulses and the BCD-to-7-segment decoder.
- User sets a two-digit BCD preset with the ones/tens buttons, then starts it.
- Counts down once per second_tick from the clock divider.
- Raises an alarm for a fixed number of seconds on reaching 00.

---
 rtl/bcd_countdown.sv | 141 ++++++++++++++
 tb/tb_bcd_countdown.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown.sv
// rtl/bcd_countdown.sv - two-digit BCD countdown timer with preset entry and alarm
module bcd_countdown #(
  parameter int ALARM_TICKS = 5
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       second_tick,
  input  logic       one_push,
  input  logic       ten_push,
  input  logic       start_pause,
  input  logic       clear,
  output logic [7:0] bcd_num,
  output logic       alarm,
  output logic       running,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] ALARM_INIT = 4'(ALARM_TICKS);

  state_t     state_q, state_d;
  logic [7:0] preset_q, preset_d;
  logic [7:0] count_q, count_d;
  logic [3:0] alarm_cnt_q, alarm_cnt_d;
  logic       alarm_d;
  logic [7:0] bcd_d;
  logic [7:0] count_dec;

  // Wrapping single-digit increment; no carry out.
  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Packed two-digit BCD decrement with borrow from tens; only used on nonzero counts.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  assign count_dec = bcd_dec(count_q);

  // Next-state and next-register logic; clear > start_pause > second_tick > digit pushes.
  always_comb begin
    state_d     = state_q;
    preset_d    = preset_q;
    count_d     = count_q;
    alarm_cnt_d = alarm_cnt_q;
    alarm_d     = alarm;
    case (state_q)
      IDLE: begin
        if (clear) begin
          preset_d = 8'h00;
        end else if (start_pause) begin
          if (preset_q != 8'h00) begin
            count_d = preset_q;
            state_d = RUN;
          end
        end else if (!second_tick) begin
          if (one_push) preset_d[3:0] = digit_inc(preset_q[3:0]);
          if (ten_push) preset_d[7:4] = digit_inc(preset_q[7:4]);
        end
      end
      RUN: begin
        if (clear) begin
          count_d = 8'h00;
          state_d = IDLE;
        end else if (start_pause) begin
          state_d = PAUSE;
        end else if (second_tick) begin
          count_d = count_dec;
          if (count_dec == 8'h00) begin
            state_d     = DONE;
            alarm_d     = 1'b1;
            alarm_cnt_d = ALARM_INIT;
          end
        end
      end
      PAUSE: begin
        if (clear) begin
          count_d = 8'h00;
          state_d = IDLE;
        end else if (start_pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (clear) begin
          alarm_d     = 1'b0;
          alarm_cnt_d = 4'd0;
          count_d     = 8'h00;
          state_d     = IDLE;
        end else if (start_pause) begin
          alarm_d     = 1'b0;
          alarm_cnt_d = 4'd0;
          count_d     = preset_q;
          state_d     = RUN;
        end else if (second_tick && alarm_cnt_q != 4'd0) begin
          alarm_cnt_d = alarm_cnt_q - 4'd1;
          if (alarm_cnt_q == 4'd1) alarm_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    bcd_d = (state_d == IDLE) ? preset_d : count_d;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      preset_q    <= 8'h00;
      count_q     <= 8'h00;
      alarm_cnt_q <= 4'd0;
      alarm       <= 1'b0;
      running     <= 1'b0;
      bcd_num     <= 8'h00;
    end else begin
      state_q     <= state_d;
      preset_q    <= preset_d;
      count_q     <= count_d;
      alarm_cnt_q <= alarm_cnt_d;
      alarm       <= alarm_d;
      running     <= (state_d == RUN);
      bcd_num     <= bcd_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// tb/tb_bcd_countdown.sv - directed bench for bcd_countdown with decimal reference model
module tb_bcd_countdown;

  localparam int ALARM = 5;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       second_tick = 1'b0;
  logic       one_push = 1'b0;
  logic       ten_push = 1'b0;
  logic       start_pause = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] bcd_num;
  logic       alarm;
  logic       running;
  logic [1:0] state;

  int vectors = 0;
  int errors  = 0;

  // Reference model in plain decimal terms.
  int m_preset = 0;
  int m_count  = 0;
  int m_state  = 0;
  int m_left   = 0;
  int m_alarm  = 0;

  bcd_countdown #(.ALARM_TICKS(ALARM)) dut (
    .clk(clk), .n_rst(n_rst), .second_tick(second_tick), .one_push(one_push),
    .ten_push(ten_push), .start_pause(start_pause), .clear(clear),
    .bcd_num(bcd_num), .alarm(alarm), .running(running), .state(state)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  function automatic int to_bcd(input int n);
    return ((n / 10) << 4) | (n % 10);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: what each pulse means for the timer, highest-priority pulse wins.
  always @(posedge clk or negedge n_rst) begin
    int p, c, s, l, a;
    if (!n_rst) begin
      m_preset <= 0; m_count <= 0; m_state <= 0; m_left <= 0; m_alarm <= 0;
    end else begin
      p = m_preset; c = m_count; s = m_state; l = m_left; a = m_alarm;
      if (clear) begin
        if (s == 0) p = 0;
        else begin s = 0; c = 0; a = 0; l = 0; end
      end else if (start_pause) begin
        case (s)
          0: if (p != 0) begin c = p; s = 1; end
          1: s = 2;
          2: s = 1;
          default: begin c = p; a = 0; l = 0; s = 1; end
        endcase
      end else if (second_tick) begin
        if (s == 1) begin
          c = c - 1;
          if (c == 0) begin s = 3; a = 1; l = ALARM; end
        end else if (s == 3 && l > 0) begin
          l = l - 1;
          if (l == 0) a = 0;
        end
      end else if (s == 0) begin
        if (one_push) p = (p / 10) * 10 + ((p % 10) + 1) % 10;
        if (ten_push) p = (((p / 10) + 1) % 10) * 10 + (p % 10);
      end
      m_preset <= p; m_count <= c; m_state <= s; m_left <= l; m_alarm <= a;
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    check("model_bcd",     int'(bcd_num), to_bcd(m_state == 0 ? m_preset : m_count));
    check("model_alarm",   int'(alarm),   m_alarm);
    check("model_running", int'(running), (m_state == 1) ? 1 : 0);
    check("model_state",   int'(state),   m_state);
  end

  // Drive pulse bits {clear, start_pause, second_tick, ten_push, one_push} for one cycle.
  task automatic pulse(input logic [4:0] v);
    @(negedge clk);
    {clear, start_pause, second_tick, ten_push, one_push} = v;
    @(posedge clk);
    #1;
    {clear, start_pause, second_tick, ten_push, one_push} = 5'b0;
  endtask

  task automatic repeat_pulse(input logic [4:0] v, input int n);
    for (int i = 0; i < n; i++) pulse(v);
  endtask

  localparam logic [4:0] P_ONE = 5'b00001, P_TEN = 5'b00010, P_TICK = 5'b00100,
                         P_SP  = 5'b01000, P_CLR = 5'b10000;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_bcd",   int'(bcd_num), 8'h00);
    check("reset_state", int'(state),   0);
    check("reset_alarm", int'(alarm),   0);
    n_rst = 1'b1;

    // Preset entry with tens wrap
    repeat_pulse(P_ONE, 3);
    repeat_pulse(P_TEN, 12);
    check("preset_23", int'(bcd_num), 8'h23);
    pulse(P_CLR);
    check("preset_clear", int'(bcd_num), 8'h00);
    pulse(P_ONE | P_TEN);
    check("both_push", int'(bcd_num), 8'h11);
    pulse(P_CLR);

    // Countdown with borrow
    pulse(P_TEN);
    repeat_pulse(P_ONE, 2);
    pulse(P_SP);
    check("run_12", int'(bcd_num), 8'h12);
    check("run_running", int'(running), 1);
    check("run_state", int'(state), 1);
    pulse(P_TICK); check("run_11", int'(bcd_num), 8'h11);
    pulse(P_TICK); check("run_10", int'(bcd_num), 8'h10);
    pulse(P_TICK); check("run_09", int'(bcd_num), 8'h09);
    pulse(P_CLR);
    check("clr_run_preset", int'(bcd_num), 8'h12);
    pulse(P_CLR);

    // Zero and alarm
    repeat_pulse(P_ONE, 2);
    pulse(P_SP);
    repeat_pulse(P_TICK, 2);
    check("done_state", int'(state), 3);
    check("done_bcd", int'(bcd_num), 8'h00);
    check("done_alarm", int'(alarm), 1);
    repeat_pulse(P_TICK, ALARM - 1);
    check("alarm_held", int'(alarm), 1);
    pulse(P_TICK);
    check("alarm_off", int'(alarm), 0);
    repeat_pulse(P_TICK, 3);
    check("done_stay", int'(state), 3);
    check("done_nowrap", int'(bcd_num), 8'h00);
    pulse(P_SP);
    check("restart_bcd", int'(bcd_num), 8'h02);
    check("restart_state", int'(state), 1);
    pulse(P_CLR);
    pulse(P_CLR);

    // Pause / resume
    repeat_pulse(P_ONE, 5);
    pulse(P_SP);
    pulse(P_TICK); check("pr_04", int'(bcd_num), 8'h04);
    pulse(P_SP);
    repeat_pulse(P_TICK, 4);
    check("pause_hold", int'(bcd_num), 8'h04);
    check("pause_state", int'(state), 2);
    pulse(P_SP);
    pulse(P_TICK); check("resume_03", int'(bcd_num), 8'h03);

    // Coincident pulses
    pulse(P_TICK | P_SP);
    check("tick_sp_state", int'(state), 2);
    check("tick_sp_bcd", int'(bcd_num), 8'h03);
    pulse(P_SP);
    pulse(P_CLR | P_SP);
    check("clr_sp_state", int'(state), 0);
    check("clr_sp_bcd", int'(bcd_num), 8'h05);
    pulse(P_CLR);
    pulse(P_SP);
    check("start_zero", int'(state), 0);

    // Async reset mid-run at 37
    repeat_pulse(P_TEN, 3);
    repeat_pulse(P_ONE, 7);
    pulse(P_SP);
    check("pre_rst_bcd", int'(bcd_num), 8'h37);
    @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_bcd", int'(bcd_num), 8'h00);
    check("arst_state", int'(state), 0);
    check("arst_alarm", int'(alarm), 0);
    @(negedge clk);
    n_rst = 1'b1;
    pulse(P_SP);
    check("arst_preset_gone", int'(state), 0);

    repeat (2) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
